// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU result queue
//
// alu_op_t      : 2-bit ALU op code, carried through unmodified
// FLG_*         : bit positions of the ALU flags inside a packed flag vector
// alu_entry_t   : one queued result {op, y, flags}, 15 bits
// pack_flags    : builds {less,is_eq,greater,overflow,parity}
// cmp_onehot    : true when exactly one compare flag is set
package alu_pkg;

  typedef logic [1:0] alu_op_t;

  localparam int FLAGS_W    = 5;
  localparam int FLG_PARITY = 0;
  localparam int FLG_OVF    = 1;
  localparam int FLG_GT     = 2;
  localparam int FLG_EQ     = 3;
  localparam int FLG_LT     = 4;

  typedef struct packed {
    alu_op_t            op;
    logic [7:0]         y;
    logic [FLAGS_W-1:0] flags;
  } alu_entry_t;

  function automatic logic [FLAGS_W-1:0] pack_flags(
    input logic less,
    input logic is_eq,
    input logic greater,
    input logic overflow,
    input logic parity
  );
    logic [FLAGS_W-1:0] f;
    f             = '0;
    f[FLG_LT]     = less;
    f[FLG_EQ]     = is_eq;
    f[FLG_GT]     = greater;
    f[FLG_OVF]    = overflow;
    f[FLG_PARITY] = parity;
    return f;
  endfunction

  // The comparator flags occupy bits FLG_GT..FLG_LT contiguously.
  function automatic logic cmp_onehot(input logic [FLAGS_W-1:0] f);
    return $countones(f[FLG_LT:FLG_GT]) == 1;
  endfunction

endpackage

// File: rtl/alu_result_queue_if.sv
// rtl/alu_result_queue_if.sv - producer/consumer handshake bundle of the ALU result queue
//
// in_valid/in_ready   : producer handshake, in_op/in_y/in_* flags sampled on push
// out_valid/out_ready : consumer handshake, out_op/out_y/out_flags show head entry
// slave  : view taken by the queue
// master : view taken by the producer/consumer side
interface alu_result_queue_if import alu_pkg::*;;

  logic               in_valid;
  logic               in_ready;
  alu_op_t            in_op;
  logic [7:0]         in_y;
  logic               in_parity;
  logic               in_overflow;
  logic               in_greater;
  logic               in_is_eq;
  logic               in_less;
  logic               out_valid;
  logic               out_ready;
  alu_op_t            out_op;
  logic [7:0]         out_y;
  logic [FLAGS_W-1:0] out_flags;

  modport slave (
    input  in_valid, in_op, in_y, in_parity, in_overflow, in_greater, in_is_eq, in_less,
    input  out_ready,
    output in_ready, out_valid, out_op, out_y, out_flags
  );

  modport master (
    output in_valid, in_op, in_y, in_parity, in_overflow, in_greater, in_is_eq, in_less,
    output out_ready,
    input  in_ready, out_valid, out_op, out_y, out_flags
  );

endinterface

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - DEPTH-entry first-word-fall-through FIFO of ALU result entries
//
// clk, rst_n : clock, synchronous active-low reset (flushes pointers and count)
// push/wdata : write request and entry; ignored while full
// pop        : read request; ignored while empty
// rdata      : head entry, all-zero when empty
// full/empty : occupancy status from registered count only
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  alu_entry_t wdata,
  input  logic       pop,
  output alu_entry_t rdata,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  alu_entry_t       mem_q [DEPTH];
  alu_entry_t       mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == OCC_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage holds stale data after reset; gating on empty keeps the head at zero.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/alu_result_queue.sv
// rtl/alu_result_queue.sv - buffers ALU results and flags for writeback, counts overflows
//
// clk, rst_n : clock, synchronous active-low reset
// bus        : alu_result_queue_if.slave, producer and consumer handshakes
// clr_stats  : synchronous clear of ovf_cnt, wins over a same-edge increment
// ovf_cnt    : saturating count of accepted entries with overflow set
// flag_err   : sticky compare-flag error, built only with ALU_FLAG_CHECK_EN defined
module alu_result_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_result_queue_if.slave    bus,
  input  logic                 clr_stats,
  output logic [CNT_W-1:0]     ovf_cnt,
  output logic                 flag_err
);

  alu_entry_t       wdata;
  alu_entry_t       rdata;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  assign wdata.op    = bus.in_op;
  assign wdata.y     = bus.in_y;
  assign wdata.flags = pack_flags(bus.in_less, bus.in_is_eq, bus.in_greater,
                                  bus.in_overflow, bus.in_parity);

  // Handshakes depend on registered occupancy only, never on the opposite side.
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign push          = bus.in_valid && !full;
  assign pop           = bus.out_ready && !empty;

  alu_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign bus.out_op    = rdata.op;
  assign bus.out_y     = rdata.y;
  assign bus.out_flags = rdata.flags;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (clr_stats) begin
      ovf_cnt_d = '0;
    end else if (push && bus.in_overflow && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;

`ifdef ALU_FLAG_CHECK_EN
  logic flag_err_q, flag_err_d;

  // Sticky until reset; clr_stats deliberately leaves it alone.
  always_comb begin
    flag_err_d = flag_err_q;
    if (push && !cmp_onehot(wdata.flags)) begin
      flag_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_err_q <= 1'b0;
    end else begin
      flag_err_q <= flag_err_d;
    end
  end

  assign flag_err = flag_err_q;
`else
  assign flag_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// tb/tb_alu_result_queue.sv - scoreboard bench for alu_result_queue
module tb_alu_result_queue;
  import alu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr_stats;
  logic [CNT_W-1:0] ovf_cnt;
  logic             flag_err;

  alu_result_queue_if bus ();

  alu_result_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_stats (clr_stats),
    .ovf_cnt   (ovf_cnt),
    .flag_err  (flag_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of entries the queue should hold, plus stats.
  logic [14:0] exp_q[$];
  int          ovf_exp   = 0;
  logic        ferr_exp  = 1'b0;
  logic        head_vis  = 1'b0;
  logic        pop_now   = 1'b0;

  // Model process: checks occupancy/stats, then applies the coming edge.
  always @(negedge clk) begin
    logic accept;
    int   ncmp;
    chk("in_ready",  32'(bus.in_ready),  32'(exp_q.size() != DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    chk("ovf_cnt",   32'(ovf_cnt),       32'(ovf_exp));
    chk("flag_err",  32'(flag_err),      32'(ferr_exp));
    head_vis = (exp_q.size() != 0);
    pop_now  = head_vis && bus.out_ready;
    if (!rst_n) begin
      exp_q.delete();
      ovf_exp  = 0;
      ferr_exp = 1'b0;
    end else begin
      accept = bus.in_valid && (exp_q.size() < DEPTH);
      if (accept) begin
        exp_q.push_back({bus.in_op, bus.in_y, bus.in_less, bus.in_is_eq,
                         bus.in_greater, bus.in_overflow, bus.in_parity});
      end
      if (clr_stats) ovf_exp = 0;
      else if (accept && bus.in_overflow && ovf_exp < CNT_MAX) ovf_exp++;
`ifdef ALU_FLAG_CHECK_EN
      ncmp = int'(bus.in_greater) + int'(bus.in_is_eq) + int'(bus.in_less);
      if (accept && ncmp != 1) ferr_exp = 1'b1;
`else
      ncmp = 0;
`endif
    end
  end

  // Monitor: compares the presented head against the oldest expected entry.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (head_vis) begin
        chk("out_entry", 32'({bus.out_op, bus.out_y, bus.out_flags}), 32'(exp_q[0]));
        if (pop_now) void'(exp_q.pop_front());
      end else begin
        chk("out_zero", 32'({bus.out_op, bus.out_y, bus.out_flags}), 32'(0));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // f = {less, is_eq, greater, overflow, parity}
  task automatic drv(input logic v, input logic [1:0] op, input logic [7:0] y, input logic [4:0] f);
    bus.in_valid    = v;
    bus.in_op       = op;
    bus.in_y        = y;
    bus.in_less     = f[4];
    bus.in_is_eq    = f[3];
    bus.in_greater  = f[2];
    bus.in_overflow = f[1];
    bus.in_parity   = f[0];
  endtask

  task automatic drv_rand(input logic v);
    drv(v, 2'($urandom), 8'($urandom), 5'($urandom));
  endtask

  task automatic drain();
    drv(1'b0, 2'd0, 8'd0, 5'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (!bus.out_valid) break;
    end
    chk("drain_empty", 32'(bus.out_valid), 32'(0));
  endtask

  initial begin
    rst_n         = 1'b0;
    clr_stats     = 1'b0;
    bus.out_ready = 1'b0;
    drv(1'b0, 2'd0, 8'd0, 5'd0);
    cyc();
    cyc();
    rst_n = 1'b1;

    // Single push into empty queue: visible right after the push edge.
    drv(1'b1, 2'b00, 8'h5A, 5'b01010);
    cyc();
    drv(1'b0, 2'd0, 8'd0, 5'd0);
    chk("first_valid", 32'(bus.out_valid), 32'(1));
    chk("first_y",     32'(bus.out_y),     32'h5A);
    chk("first_flags", 32'(bus.out_flags), 32'(5'b01010));
    chk("first_ovf",   32'(ovf_cnt),       32'(1));
    cyc();
    drain();

    // Fill to DEPTH, hold a fifth entry while full, then free one slot.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drv(1'b1, 2'd1, 8'(i), 5'b00100);
      cyc();
    end
    drv(1'b1, 2'd1, 8'd5, 5'b00100);
    chk("full_in_ready", 32'(bus.in_ready), 32'(0));
    cyc();
    cyc();
    cyc();
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk("freed_in_ready", 32'(bus.in_ready), 32'(1));
    cyc();
    drain();

    // Occupancy 2 with simultaneous push and pop for 20 cycles.
    bus.out_ready = 1'b0;
    drv_rand(1'b1);
    cyc();
    drv_rand(1'b1);
    cyc();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drv_rand(1'b1);
      cyc();
    end
    drain();

    // Saturate the overflow counter, then clear against a concurrent overflow push.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 262; i++) begin
      drv(1'b1, 2'($urandom), 8'($urandom), 5'b00010);
      cyc();
    end
    chk("ovf_saturated", 32'(ovf_cnt), 32'(CNT_MAX));
    clr_stats = 1'b1;
    drv(1'b1, 2'd3, 8'hEE, 5'b00010);
    cyc();
    clr_stats = 1'b0;
    drv(1'b0, 2'd0, 8'd0, 5'd0);
    chk("ovf_cleared", 32'(ovf_cnt), 32'(0));
    drain();

    // Reset mid-operation flushes buffered entries.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 2'd2, 8'hA0 + 8'(i), 5'b00110);
      cyc();
    end
    rst_n = 1'b0;
    drv(1'b0, 2'd0, 8'd0, 5'd0);
    cyc();
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_in_ready",  32'(bus.in_ready),  32'(1));
    chk("rst_ovf",       32'(ovf_cnt),       32'(0));
    drv(1'b1, 2'd1, 8'h77, 5'b10000);
    cyc();
    drain();

    // Inconsistent compare flags: entry still delivered, error survives clr_stats.
    bus.out_ready = 1'b0;
    drv(1'b1, 2'd0, 8'h33, 5'b10100);
    cyc();
    drv(1'b0, 2'd0, 8'd0, 5'd0);
    clr_stats = 1'b1;
    cyc();
    clr_stats = 1'b0;
    cyc();
`ifdef ALU_FLAG_CHECK_EN
    chk("flag_err_sticky", 32'(flag_err), 32'(1));
`else
    chk("flag_err_tied", 32'(flag_err), 32'(0));
`endif
    drain();

    // Random traffic with back-pressure and occasional stat clears.
    for (int i = 0; i < 400; i++) begin
      drv_rand(1'($urandom_range(0, 1)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      clr_stats     = ($urandom_range(0, 49) == 0);
      cyc();
    end
    clr_stats = 1'b0;
    drain();
    cyc();
    chk("model_empty", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_queue.md
Name: alu_result_queue

Overview:
Sequential stage directly downstream of the 8-bit combinational ALU (inputs a/b/op; outputs y, parity, overflow, greater, is_eq, less). It captures each ALU result and its flags on a valid/ready handshake and buffers them in a small FIFO for the consumer (writeback/status logic). It also keeps a saturating count of overflowed results.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, 2..16
CNT_W, 8, width of the overflow statistics counter

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  ALU result present this cycle
in_ready  output  1  queue can accept (not full)
in_op  input  2  ALU op code that produced the result; carried through unmodified
in_y  input  8  ALU result y[7:0]
in_parity  input  1  ALU parity flag
in_overflow  input  1  ALU overflow flag
in_greater  input  1  ALU greater compare flag
in_is_eq  input  1  ALU equal compare flag
in_less  input  1  ALU less compare flag
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head entry
out_op  output  2  head op
out_y  output  8  head result
out_flags  output  5  head flags {less,is_eq,greater,overflow,parity}
ovf_cnt  output  CNT_W  accepted entries with overflow=1, saturating
clr_stats  input  1  synchronous clear of ovf_cnt
flag_err  output  1  sticky compare-flag consistency error (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at a rising edge): wr_ptr=rd_ptr=0, count=0; out_valid=0, in_ready=1, ovf_cnt=0, flag_err=0; out_op/out_y/out_flags read 0. Reset mid-operation flushes all entries; nothing in flight is delivered.
- Push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (count != DEPTH); registered-state only, no combinational path from out_ready.
- out_valid = (count != 0); out_* driven from head entry (first-word fall-through from storage), zero when empty.
- Latency: entry pushed at edge N into empty queue appears on out_* with out_valid=1 after edge N; earliest pop at edge N+1.
- Count: push only +1; pop only -1; push and pop same edge: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Full (count=DEPTH): in_ready=0; in_valid ignored, data dropped only by producer's choice (producer must hold). Pop while full frees a slot from next cycle.
- Empty: out_ready ignored; no pointer movement.
- Inputs sampled only on push; in_* are don't-care otherwise.
- out_* stable while out_valid=1 and out_ready=0.
- ovf_cnt: +1 on each push with in_overflow=1; holds at 2^CNT_W-1. clr_stats has priority: clear and overflow push same edge -> ovf_cnt=0.
- No state machine beyond FIFO occupancy; states EMPTY (count=0), PARTIAL, FULL (count=DEPTH) derived from count.

Optional Feature:
ALU_FLAG_CHECK_EN: when defined, each push checks that exactly one of in_greater/in_is_eq/in_less is 1; violation sets flag_err on the push edge and holds until reset (clr_stats does not clear it). Offending entry is still enqueued. When undefined, flag_err is tied 0 and no check logic is built.

Decomposition:
- Shared package alu_pkg: op code typedef (2-bit), flag index constants (FLG_PARITY=0, FLG_OVF=1, FLG_GT=2, FLG_EQ=3, FLG_LT=4), FLAGS_W=5, result entry struct {op, y, flags} (15 bits).
- One sub-module: alu_result_fifo (generic DEPTH x entry storage, pointers, count, full/empty). Top instantiates it and adds flag packing, ovf_cnt, flag check.

Test Plan:
- Reset then single push (op=2'b00, y=8'h5A, overflow=1, is_eq=1) -> next cycle out_valid=1, out_y=8'h5A, out_flags=5'b01010, ovf_cnt=1.
- Push 4 entries with out_ready=0 -> in_ready=0 after 4th; 5th in_valid held, not accepted; pop one -> in_ready=1 next cycle, FIFO order preserved (y=1,2,3,4 out in order).
- Continuous push+pop with queue at count=2 for 20 cycles -> count stays 2, pointers wrap, no loss or duplication.
- 256 overflow pushes with CNT_W=8 -> ovf_cnt saturates at 255; clr_stats with concurrent overflow push -> ovf_cnt=0.
- Fill 3 entries, assert rst_n=0 one cycle -> out_valid=0, in_ready=1, ovf_cnt=0, prior entries never appear.
- With ALU_FLAG_CHECK_EN, push greater=1, less=1 -> flag_err=1 next cycle, entry still delivered; clr_stats leaves flag_err=1; without macro flag_err stays 0.
